// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Purpose  : Shared encodings for the multi-cycle sequencer and the
//             combinational decoder: opcodes, immediate formats, ALU
//             operations and sequencer states, plus small decode helpers.
//  Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  localparam int unsigned c_OPCODE_WIDTH = 7;

  typedef enum logic [c_OPCODE_WIDTH-1:0] {
    addi = 7'b0010011,
    lw   = 7'b0000011,
    bne  = 7'b1100011
  } opcode_t;

  typedef enum logic [2:0] {
    Imm      = 3'd0,
    UpperImm = 3'd1,
    Store    = 3'd2,
    Branch   = 3'd3,
    Jump     = 3'd4
  } instr_format_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01
  } alu_op_t;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // True for the opcodes the sequencer knows how to step through.
  function automatic logic opcode_supported(input logic [c_OPCODE_WIDTH-1:0] op);
    return (op == addi) || (op == lw) || (op == bne);
  endfunction

  // Immediate format selected by a supported opcode.
  function automatic instr_format_t imm_src_of(input logic [c_OPCODE_WIDTH-1:0] op);
    return (op == bne) ? Branch : Imm;
  endfunction

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_if
//  Purpose  : Request/ready handshake between the sequencer and the shared
//             unified memory.
//  Signals  : mem_req   - sequencer requests an access
//             mem_sel   - 0 = instruction address (PC), 1 = data address
//             mem_ready - memory completes the request this cycle
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if;

  logic mem_req;
  logic mem_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_sel,
    output mem_ready
  );

endinterface : multicycle_ctrl_if
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wdog
//  Purpose  : Counts cycles a memory request waits for ready. expired is
//             raised in the cycle the count has reached MEM_TIMEOUT while
//             ready is still low; ready in that same cycle suppresses it.
//  Ports    : clk, rst (async, active-high), active (request outstanding),
//             ready (memory response), expired (timeout this cycle)
//  Revision : 1.0  initial release
// ============================================================================
module mem_wdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!active || ready) begin
      r_cnt <= '0;
    end else if (!expired) begin
      // Holds at the limit so it can never wrap back to a "fresh" value.
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = active && !ready && (r_cnt == c_CNT_W'(MEM_TIMEOUT));

endmodule : mem_wdog
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle sequencer for the RISC-V core. Steps addi, lw and
//             bne through FETCH/DECODE/EXEC/MEM/WB, drives the datapath
//             controls, counts retired instructions and faults (sticky) on
//             an illegal opcode or a memory-response timeout.
//  Ports    : clk, rst (async, active-high), run (allow new fetch),
//             instr (IR contents), EQ (ALU equal flag),
//             mem (request/ready bus, master side),
//             IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc, ALUctrl, ALUsrc,
//             ImmSrc (datapath controls), retire (pulse per instruction),
//             instret (retired count), fault (sticky)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int IMM_WIDTH    = 3,
  parameter int ALU_WIDTH    = 2,
  parameter int OPCODE_WIDTH = 7,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  EQ,
  multicycle_ctrl_if.master     mem,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  RegWrite,
  output logic                  ResultSrc,
  output logic [ALU_WIDTH-1:0]  ALUctrl,
  output logic                  ALUsrc,
  output logic [IMM_WIDTH-1:0]  ImmSrc,
  output logic                  retire,
  output logic [DATA_WIDTH-1:0] instret,
  output logic                  fault
);

  state_t                  r_state;
  logic [OPCODE_WIDTH-1:0] r_op_q;
  logic                    r_fetch_pend;   // fetch request raised, not yet answered
  logic [DATA_WIDTH-1:0]   r_instret;

  logic w_mem_req;
  logic w_mem_sel;
  logic w_expired;
  logic w_is_lw;
  logic w_is_bne;
  logic w_unused;

  assign w_is_lw  = (r_op_q == OPCODE_WIDTH'(lw));
  assign w_is_bne = (r_op_q == OPCODE_WIDTH'(bne));
  assign w_unused = ^instr[DATA_WIDTH-1:OPCODE_WIDTH];

  mem_wdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .active  (w_mem_req),
    .ready   (mem.mem_ready),
    .expired (w_expired)
  );

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FETCH;
      r_op_q       <= '0;
      r_fetch_pend <= 1'b0;
      r_instret    <= '0;
    end else begin
      if (retire) begin
        r_instret <= r_instret + 1'b1;
      end
      case (r_state)
        FETCH: begin
          if (w_mem_req && mem.mem_ready) begin
            r_state      <= DECODE;
            r_fetch_pend <= 1'b0;
          end else if (w_expired) begin
            r_state      <= FAULT;
            r_fetch_pend <= 1'b0;
          end else begin
            // Once raised, the fetch request is held until answered.
            r_fetch_pend <= w_mem_req;
          end
        end
        DECODE: begin
          r_op_q  <= instr[OPCODE_WIDTH-1:0];
          r_state <= opcode_supported(instr[OPCODE_WIDTH-1:0]) ? EXEC : FAULT;
        end
        EXEC: begin
          if (w_is_lw) begin
            r_state <= MEM;
          end else if (w_is_bne) begin
            r_state <= FETCH;
          end else begin
            r_state <= WB;
          end
        end
        MEM: begin
          if (mem.mem_ready) begin
            r_state <= WB;
          end else if (w_expired) begin
            r_state <= FAULT;
          end
        end
        WB:      r_state <= FETCH;
        FAULT:   r_state <= FAULT;
        default: r_state <= FAULT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control outputs, decoded from state and latched opcode
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_req = 1'b0;
    w_mem_sel = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 1'b0;
    ALUctrl   = ALU_WIDTH'(ALU_ADD);
    ALUsrc    = 1'b0;
    ImmSrc    = IMM_WIDTH'(Imm);
    retire    = 1'b0;
    fault     = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_req = run || r_fetch_pend;
        IRWrite   = w_mem_req && mem.mem_ready;
      end
      EXEC: begin
        ImmSrc = IMM_WIDTH'(imm_src_of(r_op_q));
        if (w_is_bne) begin
          ALUctrl = ALU_WIDTH'(ALU_SUB);
          PCWrite = 1'b1;
          PCsrc   = ~EQ;
          retire  = 1'b1;
        end else begin
          ALUsrc  = 1'b1;
        end
      end
      MEM: begin
        w_mem_req = 1'b1;
        w_mem_sel = 1'b1;
        ALUsrc    = 1'b1;
        ImmSrc    = IMM_WIDTH'(imm_src_of(r_op_q));
      end
      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = w_is_lw;
        PCWrite   = 1'b1;
        ALUsrc    = 1'b1;
        ImmSrc    = IMM_WIDTH'(imm_src_of(r_op_q));
        retire    = 1'b1;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        fault = 1'b0;
      end
    endcase
  end

  assign mem.mem_req = w_mem_req;
  assign mem.mem_sel = w_mem_sel;
  assign instret     = r_instret;

endmodule : multicycle_ctrl
`default_nettype wire
